// File: rtl/midi_pkg.sv
// midi_pkg: shared types, constants and helpers for the MIDI transmit path.
// Holds the scheduler state encoding and MIDI byte classification.
package midi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_NEXT    = 3'd5
    } midi_tx_state_t;

    localparam logic [1:0] MIDI_MAX_MSG_LEN = 2'd3;
    localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;
    localparam logic [7:0] MIDI_SYSCOM_MIN  = 8'hF0;

    // Channel voice/mode status: 80..EF.
    function automatic logic is_channel_status(input logic [7:0] b);
        return b[7] && (b < MIDI_SYSCOM_MIN);
    endfunction

    // System common / sysex status: F0..F7.
    function automatic logic is_syscom_status(input logic [7:0] b);
        return (b >= MIDI_SYSCOM_MIN) && (b < MIDI_RT_MIN);
    endfunction

    // Byte i of a packed {status, data1, data2} message.
    function automatic logic [7:0] msg_byte(
        input logic [23:0] m,
        input logic [1:0]  i
    );
        logic [7:0] b;
        case (i)
            2'd0:    b = m[23:16];
            2'd1:    b = m[15:8];
            default: b = m[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/midi_rr_arbiter.sv
// midi_rr_arbiter: rotating-priority arbiter for the MIDI message sources.
// Ports: CLOCK_25, reset_reg (async, active high), req, advance (LOAD strobe),
//        grant (one-hot), grant_idx, grant_valid.
module midi_rr_arbiter
    import midi_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       CLOCK_25,
    input  logic                       reset_reg,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int IW = $clog2(NUM_REQ);

    // Index searched first: one past the last granted requester.
    logic [IW-1:0] ptr;

    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IW'(j);
            end
        end
    end

    always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
        if (reset_reg) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            if (int'(grant_idx) == NUM_REQ - 1)
                ptr <= '0;
            else
                ptr <= grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/midi_tx_scheduler.sv
// midi_tx_scheduler: shares one MIDI UART transmitter between several
// message sources, with real-time bytes inserted between message bytes.
// Ports: CLOCK_25, reset_reg (async, active high);
//        req_valid/req_msg/req_len -> req_ack  (round-robin message sources);
//        rt_valid/rt_byte -> rt_ack            (real-time byte, top priority);
//        midi_out_ready -> midi_send_byte/midi_out_data (UART handshake);
//        busy, grant_id, err_timeout           (status).
// Build option: MIDI_TX_RUNNING_STATUS_EN enables running-status compression.
module midi_tx_scheduler
    import midi_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                       CLOCK_25,
    input  logic                       reset_reg,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*24-1:0]      req_msg,
    input  logic [NUM_REQ*2-1:0]       req_len,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic                       rt_valid,
    input  logic [7:0]                 rt_byte,
    output logic                       rt_ack,
    input  logic                       midi_out_ready,
    output logic                       midi_send_byte,
    output logic [7:0]                 midi_out_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    midi_tx_state_t state;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    // Message buffer; buf_idx is the next byte to launch.
    logic [23:0] buf_msg;
    logic [1:0]  buf_len;
    logic [1:0]  buf_idx;

    logic [7:0]    data_q;
    logic          launch_rt;
    logic [CW-1:0] to_cnt;

    logic [23:0] ld_msg;
    logic [1:0]  ld_raw_len;
    logic [1:0]  ld_len;
    logic [1:0]  ld_start;
    logic        skip_status;
    logic        timeout_hit;

    midi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .CLOCK_25    (CLOCK_25),
        .reset_reg   (reset_reg),
        .req         (req_valid),
        .advance     (state == ST_LOAD),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        ld_msg     = req_msg[int'(arb_idx)*24 +: 24];
        ld_raw_len = req_len[int'(arb_idx)*2 +: 2];
        ld_len     = (ld_raw_len > MIDI_MAX_MSG_LEN) ? MIDI_MAX_MSG_LEN
                                                     : ld_raw_len;
        ld_start   = skip_status ? 2'd1 : 2'd0;
    end

    // Ready still high when the wait budget runs out: the UART never
    // picked the byte up.
    assign timeout_hit = (state == ST_WAIT_LO) && midi_out_ready &&
                         (to_cnt == CW'(ACK_TIMEOUT));

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] last_status;

    // A repeated channel status may be omitted; the receiver reuses it.
    assign skip_status = is_channel_status(ld_msg[23:16]) &&
                         (ld_msg[23:16] == last_status);

    always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
        if (reset_reg) begin
            last_status <= '0;
        end else if (timeout_hit) begin
            last_status <= '0;
        end else if (state == ST_LOAD && arb_valid &&
                     ld_len != 2'd0 && !skip_status) begin
            if (is_channel_status(ld_msg[23:16]))
                last_status <= ld_msg[23:16];
            else if (is_syscom_status(ld_msg[23:16]))
                last_status <= '0;
        end
    end
`else
    assign skip_status = 1'b0;
`endif

    always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
        if (reset_reg) begin
            state     <= ST_IDLE;
            buf_msg   <= '0;
            buf_len   <= '0;
            buf_idx   <= '0;
            data_q    <= '0;
            launch_rt <= 1'b0;
            to_cnt    <= '0;
            grant_id  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (midi_out_ready) begin
                        if (rt_valid) begin
                            data_q    <= rt_byte;
                            launch_rt <= 1'b1;
                            state     <= ST_LAUNCH;
                        end else if (|req_valid) begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (!arb_valid) begin
                        // Request withdrawn before it was taken.
                        state <= ST_IDLE;
                    end else begin
                        grant_id <= arb_idx;
                        buf_msg  <= ld_msg;
                        buf_len  <= ld_len;
                        if (ld_start < ld_len) begin
                            data_q    <= msg_byte(ld_msg, ld_start);
                            launch_rt <= 1'b0;
                            buf_idx   <= ld_start + 2'd1;
                            state     <= ST_LAUNCH;
                        end else begin
                            buf_idx <= ld_len;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_LAUNCH: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!midi_out_ready) begin
                        state <= ST_WAIT_HI;
                    end else if (timeout_hit) begin
                        buf_len <= '0;
                        buf_idx <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                ST_WAIT_HI: begin
                    if (midi_out_ready)
                        state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (rt_valid) begin
                        // Buffer left untouched; resumes after this byte.
                        data_q    <= rt_byte;
                        launch_rt <= 1'b1;
                        state     <= ST_LAUNCH;
                    end else if (buf_idx < buf_len) begin
                        data_q    <= msg_byte(buf_msg, buf_idx);
                        launch_rt <= 1'b0;
                        buf_idx   <= buf_idx + 2'd1;
                        state     <= ST_LAUNCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state != ST_IDLE);
        midi_send_byte = (state == ST_LAUNCH);
        rt_ack         = (state == ST_LAUNCH) && launch_rt;
        req_ack        = (state == ST_LOAD) ? arb_grant : '0;
        err_timeout    = timeout_hit;
        midi_out_data  = data_q;
    end

endmodule

// File: tb/tb_midi_tx_scheduler.sv
// tb_midi_tx_scheduler: directed bench with a UART model and a byte/grant
// scoreboard for midi_tx_scheduler.
module tb_midi_tx_scheduler;

    localparam int N = 4;

    logic           CLOCK_25 = 1'b0;
    logic           reset_reg;
    logic [N-1:0]   req_valid;
    logic [N*24-1:0] req_msg;
    logic [N*2-1:0] req_len;
    logic [N-1:0]   req_ack;
    logic           rt_valid;
    logic [7:0]     rt_byte;
    logic           rt_ack;
    logic           midi_out_ready = 1'b1;
    logic           midi_send_byte;
    logic [7:0]     midi_out_data;
    logic           busy;
    logic [1:0]     grant_id;
    logic           err_timeout;

    typedef struct {
        logic [7:0] b;
        logic       rt;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int raise_tok[N];
    int drop_tok[N];
    int rt_raise = 0;
    int rt_drop = 0;
    logic [N-1:0] drop_pend = '0;
    bit   gid_pend = 0;
    int   gid_exp = 0;
    bit   no_drop = 0;
    bit   uart_busy = 0;
    int   uart_cnt = 0;
    int   strobes = 0;
    int   strobe_cyc = 0;
    int   rise_cyc = 0;
    int   err_cnt = 0;
    int   err_cyc = 0;

    midi_tx_scheduler #(
        .NUM_REQ     (N),
        .ACK_TIMEOUT (1023)
    ) dut (
        .CLOCK_25       (CLOCK_25),
        .reset_reg      (reset_reg),
        .req_valid      (req_valid),
        .req_msg        (req_msg),
        .req_len        (req_len),
        .req_ack        (req_ack),
        .rt_valid       (rt_valid),
        .rt_byte        (rt_byte),
        .rt_ack         (rt_ack),
        .midi_out_ready (midi_out_ready),
        .midi_send_byte (midi_send_byte),
        .midi_out_data  (midi_out_data),
        .busy           (busy),
        .grant_id       (grant_id),
        .err_timeout    (err_timeout)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    always @(posedge CLOCK_25) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++)
            req_valid[i] = (raise_tok[i] != drop_tok[i]);
        rt_valid = (rt_raise != rt_drop);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_byte(logic [7:0] b, logic rt, int gap);
        exp_t e;
        e.b = b;
        e.rt = rt;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic send_req(int i, logic [23:0] m, logic [1:0] l);
        req_msg[i*24 +: 24] = m;
        req_len[i*2 +: 2] = l;
        raise_tok[i]++;
    endtask

    task automatic exp_msg3(logic [23:0] m);
        exp_byte(m[23:16], 1'b0, -1);
        exp_byte(m[15:8], 1'b0, 2);
        exp_byte(m[7:0], 1'b0, 2);
    endtask

    task automatic wait_drain(string tag, int budget);
        int k;
        k = 0;
        while (k < budget &&
               !(exp_q.size() == 0 && gnt_q.size() == 0 && !busy &&
                 midi_out_ready === 1'b1 && req_valid == '0 && !rt_valid)) begin
            @(negedge CLOCK_25);
            k++;
        end
        check({tag, "_drain"}, 32'(k < budget), 1);
        @(negedge CLOCK_25);
    endtask

    task automatic wait_strobes(string tag, int n, int budget);
        int k;
        k = 0;
        while (k < budget && strobes < n) begin
            @(negedge CLOCK_25);
            k++;
        end
        check({tag, "_strobe_wait"}, 32'(strobes >= n), 1);
    endtask

    // UART model, scoreboard pop and requester behaviour.
    always @(negedge CLOCK_25) begin
        exp_t e;
        if (uart_busy) begin
            uart_cnt++;
            if (uart_cnt == 5)
                midi_out_ready = 1'b0;
            if (uart_cnt == 45) begin
                midi_out_ready = 1'b1;
                rise_cyc = cyc;
                uart_busy = 0;
            end
        end
        if (midi_send_byte) begin
            strobes++;
            strobe_cyc = cyc;
            check("uart_idle_at_strobe", 32'(uart_busy), 0);
            check("byte_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tx_byte", 32'(midi_out_data), 32'(e.b));
                check("rt_ack_with_strobe", 32'(rt_ack), 32'(e.rt));
                if (e.gap >= 0)
                    check("byte_gap", 32'(cyc - rise_cyc), 32'(e.gap));
            end
            uart_busy = !no_drop;
            uart_cnt = 0;
        end
        if (gid_pend) begin
            check("grant_id", 32'(grant_id), 32'(gid_exp));
            gid_pend = 0;
        end
        for (int i = 0; i < N; i++)
            if (drop_pend[i]) drop_tok[i]++;
        drop_pend = req_ack;
        if (req_ack != '0) begin
            check("ack_expected", 32'(gnt_q.size() != 0), 1);
            if (gnt_q.size() != 0) begin
                gid_exp = gnt_q.pop_front();
                check("req_ack", 32'(req_ack), 32'(1 << gid_exp));
                gid_pend = 1;
            end
        end
        if (rt_ack) rt_drop++;
        if (err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        int k;
        int s0;
        reset_reg = 1'b1;
        req_msg = '0;
        req_len = '0;
        rt_byte = '0;
        repeat (3) @(negedge CLOCK_25);
        check("rst_busy", 32'(busy), 0);
        check("rst_send", 32'(midi_send_byte), 0);
        check("rst_data", 32'(midi_out_data), 0);
        check("rst_gid", 32'(grant_id), 0);
        check("rst_acks", 32'({req_ack, rt_ack, err_timeout}), 0);
        reset_reg = 1'b0;
        @(negedge CLOCK_25);

        // Round robin: 0,1,2 held together, 0 re-raised after its ack.
        send_req(0, 24'h910102, 2'd2);
        send_req(1, 24'h920304, 2'd2);
        send_req(2, 24'h930506, 2'd2);
        gnt_q = '{0, 1, 2, 0};
        exp_byte(8'h91, 0, -1); exp_byte(8'h01, 0, 2);
        exp_byte(8'h92, 0, -1); exp_byte(8'h03, 0, 2);
        exp_byte(8'h93, 0, -1); exp_byte(8'h05, 0, 2);
        exp_byte(8'h94, 0, -1); exp_byte(8'h07, 0, 2);
        k = 0;
        while (k < 100 && gnt_q.size() > 3) begin
            @(negedge CLOCK_25);
            k++;
        end
        check("rr_first_ack", 32'(gnt_q.size()), 3);
        repeat (2) @(negedge CLOCK_25);
        send_req(0, 24'h940708, 2'd2);
        wait_drain("rr", 2000);

        // Single message with latency checks.
        send_req(0, 24'h903C64, 2'd3);
        gnt_q.push_back(0);
        exp_msg3(24'h903C64);
        @(negedge CLOCK_25);
        check("lat_ack", 32'(req_ack), 32'h1);
        @(negedge CLOCK_25);
        check("lat_strobe", 32'(midi_send_byte), 1);
        wait_drain("single", 500);
        check("single_idle", 32'(busy), 0);

        // Real-time byte from IDLE.
        rt_byte = 8'hFA;
        rt_raise++;
        exp_byte(8'hFA, 1, -1);
        @(negedge CLOCK_25);
        check("rt_lat_strobe", 32'(midi_send_byte), 1);
        check("rt_lat_ack", 32'(rt_ack), 1);
        wait_drain("rt_idle", 300);

        // Real-time insertion during the 2nd byte.
        s0 = strobes;
        send_req(1, 24'hB0077F, 2'd3);
        gnt_q.push_back(1);
        exp_byte(8'hB0, 0, -1); exp_byte(8'h07, 0, 2);
        exp_byte(8'hF8, 1, 2); exp_byte(8'h7F, 0, 2);
        wait_strobes("rt_ins", s0 + 2, 300);
        rt_byte = 8'hF8;
        rt_raise++;
        wait_drain("rt_ins", 600);

        // Running status.
        send_req(0, 24'h903C64, 2'd3);
        gnt_q.push_back(0);
        exp_msg3(24'h903C64);
        wait_drain("rs_a", 500);
        send_req(0, 24'h904064, 2'd3);
        gnt_q.push_back(0);
`ifdef MIDI_TX_RUNNING_STATUS_EN
        exp_byte(8'h40, 0, -1); exp_byte(8'h64, 0, 2);
`else
        exp_msg3(24'h904064);
`endif
        wait_drain("rs_b", 500);
        send_req(0, 24'hF07E7F, 2'd3);
        gnt_q.push_back(0);
        exp_msg3(24'hF07E7F);
        wait_drain("rs_f0", 500);
        send_req(0, 24'h903C64, 2'd3);
        gnt_q.push_back(0);
        exp_msg3(24'h903C64);
        wait_drain("rs_after_f0", 500);

        // Timeout: UART never drops ready.
        no_drop = 1;
        err_cnt = 0;
        send_req(2, 24'h951122, 2'd3);
        gnt_q.push_back(2);
        exp_byte(8'h95, 0, -1);
        k = 0;
        while (k < 1300 && err_cnt == 0) begin
            @(negedge CLOCK_25);
            k++;
        end
        check("timeout_seen", 32'(err_cnt), 1);
        check("timeout_delay", 32'(err_cyc - strobe_cyc), 1024);
        @(negedge CLOCK_25);
        check("timeout_pulse_width", 32'(err_timeout), 0);
        check("timeout_idle", 32'(busy), 0);
        no_drop = 0;
        wait_drain("timeout", 100);
        send_req(2, 24'h953344, 2'd3);
        gnt_q.push_back(2);
        exp_msg3(24'h953344);
        wait_drain("after_timeout", 500);
        check("timeout_single_pulse", 32'(err_cnt), 1);

        // Reset in WAIT_HI discards the buffer.
        s0 = strobes;
        send_req(3, 24'h960102, 2'd3);
        gnt_q.push_back(3);
        exp_byte(8'h96, 0, -1);
        wait_strobes("rst_mid", s0 + 1, 100);
        k = 0;
        while (k < 50 && midi_out_ready !== 1'b0) begin
            @(negedge CLOCK_25);
            k++;
        end
        check("rst_mid_ready_low", 32'(midi_out_ready), 0);
        repeat (3) @(negedge CLOCK_25);
        #5 reset_reg = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_send", 32'(midi_send_byte), 0);
        check("rst_mid_data", 32'(midi_out_data), 0);
        check("rst_mid_gid", 32'(grant_id), 0);
        @(negedge CLOCK_25);
        reset_reg = 1'b0;
        repeat (80) @(negedge CLOCK_25);
        check("rst_mid_no_more_bytes", 32'(strobes - s0), 1);
        check("rst_mid_queue_empty", 32'(exp_q.size()), 0);
        check("rst_mid_idle", 32'(busy), 0);

        // Length 0: ack without a strobe.
        s0 = strobes;
        send_req(1, 24'h000000, 2'd0);
        gnt_q.push_back(1);
        wait_drain("len0", 100);
        check("len0_no_strobe", 32'(strobes - s0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
